// File: rtl/musa_key_conditioner.sv
// rtl/musa_key_conditioner.sv - key/switch sync, debounce, read trigger, selector and core clock-enable
module musa_key_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_WIDTH       = 20,
  parameter int STEP_CNT_WIDTH  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      key_read_n,
  input  logic                      key_step_n,
  input  logic                      sw_seletor,
  input  logic                      sw_run,
  output logic                      read_pulse,
  output logic                      seletor_out,
  output logic                      core_en,
  output logic [STEP_CNT_WIDTH-1:0] step_count
);

  // Bit order of the conditioned inputs: 0 read key, 1 step key, 2 selector, 3 run.
  localparam logic [3:0]           KEY_INVERT = 4'b0011;
  localparam logic [CNT_WIDTH-1:0] DB_LAST    = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_STEP_IDLE = 2'd1,
    ST_STEP_FIRE = 2'd2
  } state_t;

  logic [3:0]           raw_in;
  logic [3:0]           sync1;
  logic [3:0]           sync2;
  logic [3:0]           sample;
  logic [3:0]           stable;
  logic [1:0]           key_q;
  logic [CNT_WIDTH-1:0] db_cnt [4];
  logic                 step_evt;
  logic                 run_lvl;
  state_t               state;
  state_t               state_nxt;

  assign raw_in      = {sw_run, sw_seletor, key_step_n, key_read_n};
  // Keys are active low on the board; after inversion 1 means pressed.
  assign sample      = sync2 ^ KEY_INVERT;
  assign seletor_out = stable[2];
  assign run_lvl     = stable[3];

  // Two-flop synchroniser for every raw input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw_in;
      sync2 <= sync1;
    end
  end

  // Per-input debounce: a level must differ for DEBOUNCE_CYCLES consecutive samples to be accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sample[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          stable[i] <= ~stable[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Registered rising-edge detect on the debounced keys; releases give no event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q      <= '0;
      read_pulse <= 1'b0;
      step_evt   <= 1'b0;
    end else begin
      key_q      <= stable[1:0];
      read_pulse <= stable[0] & ~key_q[0];
      step_evt   <= stable[1] & ~key_q[1];
    end
  end

  // Core-enable FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_STEP_IDLE;
    else        state <= state_nxt;
  end

  // Next state: step events outside STEP_IDLE, or while the reader owns memory, are dropped.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:       if (!run_lvl) state_nxt = ST_STEP_IDLE;
      ST_STEP_IDLE: begin
        if (run_lvl)                        state_nxt = ST_RUN;
        else if (step_evt && !seletor_out)  state_nxt = ST_STEP_FIRE;
      end
      ST_STEP_FIRE: state_nxt = ST_STEP_IDLE;
      default:      state_nxt = ST_STEP_IDLE;
    endcase
  end

  // Core enable: active in RUN and STEP_FIRE unless the LCD reader holds the memory port.
  always_comb begin
    core_en = 1'b0;
    if ((state == ST_RUN || state == ST_STEP_FIRE) && !seletor_out) core_en = 1'b1;
  end

  // Count of executed core cycles; wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       step_count <= '0;
    else if (core_en) step_count <= step_count + 1'b1;
  end

endmodule

// File: tb/tb_musa_key_conditioner.sv
// tb/tb_musa_key_conditioner.sv - directed self-checking bench for musa_key_conditioner
module tb_musa_key_conditioner;

  logic       clk;
  logic       rst_n;
  logic       key_read_n;
  logic       key_step_n;
  logic       sw_seletor;
  logic       sw_run;
  logic       read_pulse;
  logic       seletor_out;
  logic       core_en;
  logic [3:0] step_count;

  int checks = 0;
  int errors = 0;

  musa_key_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .CNT_WIDTH(20),
    .STEP_CNT_WIDTH(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .key_read_n(key_read_n),
    .key_step_n(key_step_n),
    .sw_seletor(sw_seletor),
    .sw_run(sw_run),
    .read_pulse(read_pulse),
    .seletor_out(seletor_out),
    .core_en(core_en),
    .step_count(step_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    key_read_n = 1'b1;
    key_step_n = 1'b1;
    sw_seletor = 1'b0;
    sw_run     = 1'b0;

    // Reset state
    repeat (3) tick();
    check("reset_read_pulse", 16'(read_pulse), 16'd0);
    check("reset_seletor", 16'(seletor_out), 16'd0);
    check("reset_core_en", 16'(core_en), 16'd0);
    check("reset_step_count", 16'(step_count), 16'd0);
    rst_n = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      check("settle_read_pulse", 16'(read_pulse), 16'd0);
      check("settle_core_en", 16'(core_en), 16'd0);
    end

    // Clean read press: single pulse 7 edges after the input changes
    key_read_n = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      check("press_read_pulse", 16'(read_pulse), 16'(i == 7));
    end
    key_read_n = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      check("release_read_pulse", 16'(read_pulse), 16'd0);
    end

    // Bouncing key toggling every 2 cycles never qualifies
    for (int i = 0; i < 40; i++) begin
      key_read_n = ~i[1];
      tick();
      check("bounce_read_pulse", 16'(read_pulse), 16'd0);
    end
    key_read_n = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check("bounce_hold_read_pulse", 16'(read_pulse), 16'd0);
    end

    // Single-step with a simultaneous read press
    key_step_n = 1'b0;
    key_read_n = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      tick();
      check("step1_read_pulse", 16'(read_pulse), 16'(i == 7));
      check("step1_core_en", 16'(core_en), 16'(i == 8));
    end
    check("step1_count", 16'(step_count), 16'd1);
    key_step_n = 1'b1;
    key_read_n = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      check("step_release_core_en", 16'(core_en), 16'd0);
    end
    key_step_n = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      tick();
      check("step2_core_en", 16'(core_en), 16'(i == 8));
    end
    check("step2_count", 16'(step_count), 16'd2);
    key_step_n = 1'b1;
    for (int i = 1; i <= 10; i++) tick();
    check("step_idle_count", 16'(step_count), 16'd2);

    // Free run
    sw_run = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check("run_core_en", 16'(core_en), 16'(i >= 7));
    end
    check("run_count", 16'(step_count), 16'd5);

    // Selector override window
    sw_seletor = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      check("sel_core_en", 16'(core_en), 16'(i < 6));
      check("sel_seletor_out", 16'(seletor_out), 16'(i >= 6));
    end
    check("sel_count_frozen", 16'(step_count), 16'd11);
    sw_seletor = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check("unsel_core_en", 16'(core_en), 16'(i >= 6));
    end
    check("unsel_count", 16'(step_count), 16'd15);

    // Counter wrap
    tick();
    check("wrap_count_zero", 16'(step_count), 16'd0);
    repeat (4) tick();
    check("wrap_count_four", 16'(step_count), 16'd4);

    // Reset mid-debounce aborts the pending press
    sw_run     = 1'b0;
    key_read_n = 1'b0;
    repeat (3) tick();
    rst_n      = 1'b0;
    key_read_n = 1'b1;
    #1;
    check("midrst_step_count", 16'(step_count), 16'd0);
    check("midrst_core_en", 16'(core_en), 16'd0);
    check("midrst_read_pulse", 16'(read_pulse), 16'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      tick();
      check("postrst_read_pulse", 16'(read_pulse), 16'd0);
      check("postrst_core_en", 16'(core_en), 16'd0);
    end
    check("postrst_step_count", 16'(step_count), 16'd0);
    check("postrst_seletor", 16'(seletor_out), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/musa_key_conditioner.md
Name: musa_key_conditioner

Overview:
Front-end conditioner for the board keys and switches that drive the MUSA core top level. It synchronises and debounces the raw DE2 keys and switches. It produces a one-cycle LCD read trigger, a glitch-free memory-port selector, and a core clock-enable that supports free-run and single-step modes. Outputs feed the core's read_in, seletor and clock-enable logic directly; all logic runs on the board 50 MHz clock.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive stable samples needed to accept a new input level (10 ms at 50 MHz)
CNT_WIDTH, 20, width of each debounce counter; must hold DEBOUNCE_CYCLES
STEP_CNT_WIDTH, 16, width of the executed-cycle debug counter

Ports:
clk  input  1  board clock, 50 MHz
rst_n  input  1  asynchronous reset, active low
key_read_n  input  1  raw key[3], active low (pressed = 0)
key_step_n  input  1  raw key[2], active low, single-step request
sw_seletor  input  1  raw switch, 1 = LCD reader owns the data-memory address port
sw_run  input  1  raw switch, 1 = free-run, 0 = single-step
read_pulse  output  1  one-cycle pulse per accepted key[3] press
seletor_out  output  1  debounced selector
core_en  output  1  core clock-enable
step_count  output  STEP_CNT_WIDTH  number of cycles with core_en = 1

Behaviour:
- Reset, asynchronous, rst_n = 0:
  - All synchroniser flops, debounced levels and counters clear to 0; debounced keys clear to released.
  - FSM enters STEP_IDLE.
  - read_pulse = 0, seletor_out = 0, core_en = 0, step_count = 0.
  - Reset asserted mid-debounce or mid-step aborts the operation; no pulse is emitted on release of reset.
- Synchronisation: each of the 4 raw inputs passes through 2 flops. Keys are inverted after sync, so internal level 1 = pressed.
- Debounce, per input, identical logic:
  - Counter clears whenever the synced sample equals the stable level.
  - Counter increments on each edge where the sample differs from the stable level.
  - When the increment would reach DEBOUNCE_CYCLES, the stable level flips and the counter clears.
  - Any single matching sample restarts the count.
- Latency, N = DEBOUNCE_CYCLES: a clean level held from edge k (the first edge capturing it in sync stage 1) flips the stable level at edge k+1+N.
- Press events:
  - Rising edge of the debounced key, registered: read_pulse / step request is high for exactly the one cycle following edge k+2+N.
  - Key release produces no event.
  - Holding a key produces exactly one event.
- seletor_out = debounced sw_seletor, same latency as the stable flip.
- Core-enable FSM, states RUN, STEP_IDLE, STEP_FIRE:
  - RUN: core_en = 1. Leave to STEP_IDLE when debounced run = 0.
  - STEP_IDLE: core_en = 0. Go to RUN if run = 1; otherwise go to STEP_FIRE on a step event.
  - STEP_FIRE: core_en = 1 for exactly one cycle. Always returns to STEP_IDLE, even if run rises in the same cycle; RUN is entered on the next evaluation.
  - Override: while seletor_out = 1, core_en is forced to 0 in every state.
  - A step event arriving in STEP_IDLE while seletor_out = 1 is discarded and is not queued.
  - Step events in RUN or STEP_FIRE are discarded.
- step_count increments on every edge where core_en = 1, and wraps from all-ones to 0.
- Simultaneous read and step events are independent; both are honoured in the same cycle.

Test Plan:
- Reset with rst_n = 0 for 3 cycles, all raw inputs idle (keys = 1, switches = 0) -> every output 0, FSM in STEP_IDLE, step_count = 0.
- DEBOUNCE_CYCLES = 4; key_read_n driven 0 from edge 10 and held 50 cycles -> read_pulse high for exactly 1 cycle, after edge 16 only; no further pulse on hold or release.
- DEBOUNCE_CYCLES = 4; key_read_n toggled every 2 cycles for 40 cycles, then held 1 -> read_pulse never asserts.
- sw_run = 0, two clean key_step_n presses -> core_en high exactly 2 isolated cycles, step_count = 2.
- sw_run = 1, then sw_seletor = 1 for 20 cycles, then back to 0 -> core_en drops during the seletor_out = 1 window; step_count stops advancing in that window and resumes after.
- STEP_CNT_WIDTH = 4, sw_run = 1 for 20 enabled cycles -> step_count wraps 15 -> 0 and reads 4.
- Assert rst_n = 0 two cycles before a debounced flip would occur -> no read_pulse after reset release; all counters = 0.
